// File: rtl/spu_cfg_loader.sv
// SPU logic-op configuration loader: stream beats fill a shadow bank, which is
// copied atomically to the active bank after a guard interval. Optional readback
// port is enabled with the SPU_CFG_LOADER_READBACK_EN macro.
module spu_cfg_loader #(
  parameter int UNITS        = 8,
  parameter int CFG_BITS     = 4,
  parameter int ADDR_BITS    = 8,
  parameter int GUARD_CYCLES = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      cke,
  input  logic                      s_valid,
  output logic                      s_ready,
  input  logic [ADDR_BITS-1:0]      s_addr,
  input  logic [CFG_BITS-1:0]       s_cfg,
  input  logic                      s_last,
  output logic [UNITS*CFG_BITS-1:0] m_cfg,
  output logic                      m_commit,
  output logic                      busy,
  output logic                      err,
  input  logic                      err_clr
`ifdef SPU_CFG_LOADER_READBACK_EN
  ,
  input  logic [ADDR_BITS-1:0]      rd_addr,
  input  logic                      rd_shadow,
  output logic [CFG_BITS-1:0]       rd_data
`endif
);

  localparam int                 BANK_W     = UNITS * CFG_BITS;
  localparam logic [7:0]         GUARD_INIT = 8'(GUARD_CYCLES);
  localparam logic [ADDR_BITS:0] UNITS_LIM  = (ADDR_BITS+1)'(UNITS);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_GUARD  = 2'd2,
    ST_COMMIT = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [7:0]        guard_cnt_q, guard_cnt_d;
  logic [BANK_W-1:0] shadow_q, shadow_d;
  logic [BANK_W-1:0] active_q, active_d;
  logic              err_q, err_d;
  logic              accept_s;
  logic              addr_ok_s;

  // Handshake: beats are only taken while collecting a set and not held in reset.
  always_comb begin
    s_ready = 1'b0;
    if (reset && cke && (state_q == ST_IDLE || state_q == ST_LOAD)) begin
      s_ready = 1'b1;
    end else begin
      s_ready = 1'b0;
    end
  end

  assign accept_s  = s_valid & s_ready;
  assign addr_ok_s = ({1'b0, s_addr} < UNITS_LIM);

  // Sequencing FSM: collect beats, count the guard interval, then commit.
  always_comb begin
    state_d     = state_q;
    guard_cnt_d = guard_cnt_q;
    m_commit    = 1'b0;
    case (state_q)
      ST_IDLE, ST_LOAD: begin
        if (accept_s && s_last) begin
          if (GUARD_CYCLES == 0) begin
            state_d = ST_COMMIT;
          end else begin
            state_d     = ST_GUARD;
            guard_cnt_d = GUARD_INIT;
          end
        end else if (accept_s) begin
          state_d = ST_LOAD;
        end else begin
          state_d = state_q;
        end
      end
      ST_GUARD: begin
        // The final guard cycle moves straight to COMMIT so latency is GUARD_CYCLES+1.
        if (cke && guard_cnt_q <= 8'd1) begin
          state_d = ST_COMMIT;
        end else if (cke) begin
          guard_cnt_d = guard_cnt_q - 8'd1;
        end else begin
          guard_cnt_d = guard_cnt_q;
        end
      end
      ST_COMMIT: begin
        m_commit = cke;
        if (cke) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_COMMIT;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Bank and error-flag updates; out-of-range beats only raise err.
  always_comb begin
    shadow_d = shadow_q;
    active_d = active_q;
    err_d    = err_q;
    for (int i = 0; i < UNITS; i++) begin
      if (accept_s && addr_ok_s && s_addr == ADDR_BITS'(i)) begin
        shadow_d[i*CFG_BITS +: CFG_BITS] = s_cfg;
      end else begin
        shadow_d[i*CFG_BITS +: CFG_BITS] = shadow_q[i*CFG_BITS +: CFG_BITS];
      end
    end
    if (m_commit) begin
      active_d = shadow_q;
    end else begin
      active_d = active_q;
    end
    // Set is applied after clear so a simultaneous new error wins.
    if (cke && err_clr) begin
      err_d = 1'b0;
    end else begin
      err_d = err_q;
    end
    if (accept_s && !addr_ok_s) begin
      err_d = 1'b1;
    end else begin
      err_d = err_d;
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      guard_cnt_q <= 8'd0;
      shadow_q    <= {BANK_W{1'b0}};
      active_q    <= {BANK_W{1'b0}};
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      guard_cnt_q <= guard_cnt_d;
      shadow_q    <= shadow_d;
      active_q    <= active_d;
      err_q       <= err_d;
    end
  end

  assign m_cfg = active_q;
  assign err   = err_q;
  assign busy  = (state_q != ST_IDLE) || accept_s;

`ifdef SPU_CFG_LOADER_READBACK_EN
  logic [CFG_BITS-1:0] rd_data_q, rd_data_d;

  // Readback mux selecting shadow or active entry; unmapped addresses read zero.
  always_comb begin
    rd_data_d = rd_data_q;
    if (cke) begin
      rd_data_d = {CFG_BITS{1'b0}};
      for (int i = 0; i < UNITS; i++) begin
        if (rd_addr == ADDR_BITS'(i)) begin
          rd_data_d = rd_shadow ? shadow_q[i*CFG_BITS +: CFG_BITS]
                                : active_q[i*CFG_BITS +: CFG_BITS];
        end else begin
          rd_data_d = rd_data_d;
        end
      end
    end else begin
      rd_data_d = rd_data_q;
    end
  end

  // Readback output register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_data_q <= {CFG_BITS{1'b0}};
    end else begin
      rd_data_q <= rd_data_d;
    end
  end

  assign rd_data = rd_data_q;
`endif

endmodule

// File: tb/tb_spu_cfg_loader.sv
// Self-checking bench for spu_cfg_loader: directed scenarios then random beats,
// compared against a per-unit array model with a cke-cycle commit countdown.
module tb_spu_cfg_loader;

  localparam int UNITS        = 8;
  localparam int CFG_BITS     = 4;
  localparam int ADDR_BITS    = 8;
  localparam int GUARD_CYCLES = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        cke;
  logic        s_valid;
  logic        s_ready;
  logic [7:0]  s_addr;
  logic [3:0]  s_cfg;
  logic        s_last;
  logic [31:0] m_cfg;
  logic        m_commit;
  logic        busy;
  logic        err;
  logic        err_clr;
`ifdef SPU_CFG_LOADER_READBACK_EN
  logic [7:0]  rd_addr;
  logic        rd_shadow;
  logic [3:0]  rd_data;
  logic [3:0]  rd_exp;
`endif

  spu_cfg_loader #(
    .UNITS(UNITS), .CFG_BITS(CFG_BITS), .ADDR_BITS(ADDR_BITS), .GUARD_CYCLES(GUARD_CYCLES)
  ) dut (
    .clk(clk), .reset(reset), .cke(cke),
    .s_valid(s_valid), .s_ready(s_ready), .s_addr(s_addr), .s_cfg(s_cfg), .s_last(s_last),
    .m_cfg(m_cfg), .m_commit(m_commit), .busy(busy), .err(err), .err_clr(err_clr)
`ifdef SPU_CFG_LOADER_READBACK_EN
    , .rd_addr(rd_addr), .rd_shadow(rd_shadow), .rd_data(rd_data)
`endif
  );

  always #5 clk = ~clk;

  int         checks = 0;
  int         errors = 0;
  logic [3:0] sh_m [UNITS];
  logic [3:0] ac_m [UNITS];
  bit         err_m;
  int         rem_m;      // cke cycles left until commit (0 = nothing pending)
  bit         inset_m;
  bit         last_acc;
  bit         last_commit;

  function automatic logic [31:0] packm();
    logic [31:0] v;
    v = 32'h0;
    for (int i = 0; i < UNITS; i++) v[i*4 +: 4] = ac_m[i];
    return v;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < UNITS; i++) begin
      sh_m[i] = 4'h0;
      ac_m[i] = 4'h0;
    end
    err_m   = 1'b0;
    rem_m   = 0;
    inset_m = 1'b0;
`ifdef SPU_CFG_LOADER_READBACK_EN
    rd_exp  = 4'h0;
`endif
  endtask

  // One clock cycle: drive, check outputs mid-cycle, then advance the model.
  task automatic cyc(input bit k, input bit v, input int a, input logic [3:0] c,
                     input bit l, input bit clr);
    bit exp_ready, acc, commit_now;
    cke = k; s_valid = v; s_addr = 8'(a); s_cfg = c; s_last = l; err_clr = clr;
    exp_ready  = k && reset && (rem_m == 0);
    acc        = v && exp_ready;
    commit_now = k && reset && (rem_m == 1);
    #3;
    chk("s_ready", s_ready, exp_ready);
    chk("m_commit", m_commit, commit_now);
    chk("busy", busy, reset && (inset_m || rem_m > 0 || acc));
    chk("err", err, err_m);
    chk("m_cfg", m_cfg, packm());
`ifdef SPU_CFG_LOADER_READBACK_EN
    chk("rd_data", rd_data, rd_exp);
`endif
    last_commit = m_commit;
    last_acc    = acc;
    @(posedge clk);
    #1;
    if (!reset) begin
      model_clear();
    end else begin
`ifdef SPU_CFG_LOADER_READBACK_EN
      if (k) begin
        int ra;
        ra = rd_addr;
        rd_exp = (ra < UNITS) ? (rd_shadow ? sh_m[ra] : ac_m[ra]) : 4'h0;
      end
`endif
      if (commit_now) begin
        for (int i = 0; i < UNITS; i++) ac_m[i] = sh_m[i];
        rem_m = 0;
      end else if (k && rem_m > 1) begin
        rem_m--;
      end
      if (k && clr) err_m = 1'b0;
      if (acc) begin
        if (a < UNITS) sh_m[a] = c;
        else err_m = 1'b1;
        if (l) begin
          rem_m   = GUARD_CYCLES + 1;
          inset_m = 1'b0;
        end else begin
          inset_m = 1'b1;
        end
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, 0, 4'h0, 1'b0, 1'b0);
  endtask

  initial begin
    bit         hv;
    int         ha;
    logic [3:0] hc;
    bit         hl;

    reset = 1'b0; cke = 1'b1; s_valid = 1'b1; s_addr = 8'd0; s_cfg = 4'h5;
    s_last = 1'b0; err_clr = 1'b0;
`ifdef SPU_CFG_LOADER_READBACK_EN
    rd_addr = 8'd0; rd_shadow = 1'b0;
`endif
    model_clear();
    #12;
    chk("rst_s_ready", s_ready, 1'b0);
    chk("rst_m_commit", m_commit, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_err", err, 1'b0);
    chk("rst_m_cfg", m_cfg, 32'h0);
`ifdef SPU_CFG_LOADER_READBACK_EN
    chk("rst_rd_data", rd_data, 4'h0);
`endif
    s_valid = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;

    // Reset asserted during the guard interval discards the pending set.
    cyc(1'b1, 1'b1, 2, 4'hF, 1'b1, 1'b0);
    cyc(1'b1, 1'b0, 0, 4'h0, 1'b0, 1'b0);
    reset = 1'b0;
    model_clear();
    #1;
    chk("rstg_m_cfg", m_cfg, 32'h0);
    chk("rstg_s_ready", s_ready, 1'b0);
    chk("rstg_busy", busy, 1'b0);
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b1, 2, 4'hF, 1'b1, 1'b0);
    reset = 1'b1;
    idle(4);
    chk("rstg_m_cfg_after", m_cfg, 32'h0);

    // Basic set with commit three cycles after the last beat.
    cyc(1'b1, 1'b1, 0, 4'h2, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 3, 4'h9, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 7, 4'hE, 1'b1, 1'b0);
    idle(2);
    chk("tp1_no_early_commit", last_commit, 1'b0);
    idle(1);
    chk("tp1_commit_cycle3", last_commit, 1'b1);
    chk("tp1_m_cfg", m_cfg, 32'hE0009002);
    idle(1);
    chk("tp1_busy_drop", busy, 1'b0);

    // Same address twice in one set: last beat wins.
    cyc(1'b1, 1'b1, 1, 4'h5, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1, 4'hA, 1'b1, 1'b0);
    idle(4);
    chk("tp2_unit1", m_cfg[7:4], 4'hA);
    chk("tp2_m_cfg", m_cfg, 32'hE00090A2);

    // Out-of-range last beat: err set, commit still runs, bank unchanged.
    cyc(1'b1, 1'b1, 9, 4'h3, 1'b1, 1'b0);
    chk("tp3_err_set", err, 1'b1);
    idle(2);
    idle(1);
    chk("tp3_commit", last_commit, 1'b1);
    chk("tp3_m_cfg", m_cfg, 32'hE00090A2);
    cyc(1'b1, 1'b0, 0, 4'h0, 1'b0, 1'b1);
    chk("tp3_err_clr", err, 1'b0);
    cyc(1'b1, 1'b1, 9, 4'h3, 1'b0, 1'b1);
    chk("tp3_set_wins", err, 1'b1);
    cyc(1'b1, 1'b1, 0, 4'h2, 1'b1, 1'b1);
    idle(4);

    // cke toggling through the guard interval.
    cyc(1'b1, 1'b1, 6, 4'hC, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 1'b0, 0, 4'h0, 1'b0, 1'b0);
      chk("tp4_no_commit_cke0", last_commit, 1'b0);
      cyc(1'b1, 1'b0, 0, 4'h0, 1'b0, 1'b0);
    end
    chk("tp4_commit_3rd_cke", last_commit, 1'b1);
    chk("tp4_unit6", m_cfg[27:24], 4'hC);
    idle(1);

`ifdef SPU_CFG_LOADER_READBACK_EN
    cyc(1'b1, 1'b1, 4, 4'h6, 1'b0, 1'b0);
    rd_addr = 8'd4; rd_shadow = 1'b1;
    cyc(1'b1, 1'b0, 0, 4'h0, 1'b0, 1'b0);
    chk("rb_shadow", rd_data, 4'h6);
    rd_shadow = 1'b0;
    cyc(1'b1, 1'b0, 0, 4'h0, 1'b0, 1'b0);
    chk("rb_active", rd_data, 4'h0);
    cyc(1'b1, 1'b1, 5, 4'h1, 1'b1, 1'b0);
    idle(4);
`endif

    // Random traffic; an unaccepted beat is held until taken.
    hv = 1'b0; ha = 0; hc = 4'h0; hl = 1'b0;
    last_acc = 1'b0;
    for (int n = 0; n < 400; n++) begin
      if (!(hv && !last_acc)) begin
        hv = ($urandom_range(0, 1) == 1);
        ha = $urandom_range(0, 9);
        hc = 4'($urandom);
        hl = ($urandom_range(0, 3) == 0);
      end
`ifdef SPU_CFG_LOADER_READBACK_EN
      rd_addr   = 8'($urandom_range(0, 9));
      rd_shadow = ($urandom_range(0, 1) == 1);
`endif
      cyc(($urandom_range(0, 3) != 0), hv, ha, hc, hl, ($urandom_range(0, 7) == 0));
    end
    idle(6);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
